// File: rtl/ibex_l2_rf_pkg.sv
// Shared types and helpers for the flop-based L2 register-file bank.
package ibex_l2_rf_pkg;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_scrub_e;

   // One lane of the byte-enable merge; the caller loops over every lane of the word.
   function automatic logic [7:0] rf_merge_byte(input logic [7:0] old_byte,
                                                input logic [7:0] new_byte,
                                                input logic       be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/ibex_l2_rf_scrub_ctrl.sv
// Sequential scrub engine: walks every word once, issuing a zero-write per cycle.
//
// state    | meaning
// RF_IDLE  | no scrub in progress, user port owns the array
// RF_CLEAR | zeroing word[ptr_q], one word per cycle
module ibex_l2_rf_scrub_ctrl
   import ibex_l2_rf_pkg::*;
#(
   parameter int unsigned NumWords  = 28,
   parameter int unsigned AddrWidth = $clog2(NumWords)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   output logic                 busy_o,
   output logic                 scrub_we_o,
   output logic [AddrWidth-1:0] scrub_addr_o
);

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
   localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

   rf_scrub_e            state_q;
   logic [AddrWidth-1:0] ptr_q;
   logic                 busy_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RF_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            RF_IDLE: begin
               if (clear_i) begin
                  state_q <= RF_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RF_CLEAR: begin
               // clear_i is deliberately not looked at here: a scrub never restarts.
               if (ptr_q == LastAddr) begin
                  state_q <= RF_IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + AddrOne;
               end
            end
            default: begin
               state_q <= RF_IDLE;
               ptr_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign scrub_we_o   = (state_q == RF_CLEAR);
   assign scrub_addr_o = ptr_q;

endmodule

// File: rtl/ibex_l2_rf_bank.sv
// Flop-based L2 register-file bank: byte-enabled write port, registered read port
// with write-first forwarding, range errors, and a zeroing scrub engine.
module ibex_l2_rf_bank
   import ibex_l2_rf_pkg::*;
#(
   parameter  int unsigned DataWidth = 32,
   parameter  int unsigned NumWords  = 28,
   parameter  bit          ZeroWord0 = 1'b1,
   localparam int unsigned AddrWidth = $clog2(NumWords),
   localparam int unsigned BeWidth   = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   output logic                 busy_o,
   input  logic                 we_i,
   input  logic [AddrWidth-1:0] waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [BeWidth-1:0]   wbe_i,
   output logic                 werr_o,
   input  logic                 rreq_i,
   input  logic [AddrWidth-1:0] raddr_i,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 rerr_o
);

   logic                 busy;
   logic                 scrub_we;
   logic [AddrWidth-1:0] scrub_addr;

   ibex_l2_rf_scrub_ctrl #(
      .NumWords (NumWords),
      .AddrWidth(AddrWidth)
   ) u_scrub_ctrl (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (clear_i),
      .busy_o      (busy),
      .scrub_we_o  (scrub_we),
      .scrub_addr_o(scrub_addr)
   );

   logic [DataWidth-1:0] mem_q [NumWords];
   logic [DataWidth-1:0] mem_d [NumWords];
   logic                 werr_q,   werr_d;
   logic                 rvalid_q, rvalid_d;
   logic                 rerr_q,   rerr_d;
   logic [DataWidth-1:0] rdata_q,  rdata_d;

   logic                 wr_in_range, rd_in_range, wr_en;
   logic [DataWidth-1:0] wr_old, wr_merged;

   always_comb begin
      mem_d       = mem_q;
      werr_d      = 1'b0;
      rvalid_d    = rreq_i;
      rerr_d      = 1'b0;
      rdata_d     = rdata_q;
      wr_old      = '0;
      wr_merged   = '0;
      wr_in_range = 32'(waddr_i) < NumWords;
      rd_in_range = 32'(raddr_i) < NumWords;
      wr_en       = we_i && !busy && wr_in_range && !(ZeroWord0 && (waddr_i == '0));
      werr_d      = we_i && (busy || !wr_in_range);

      // Out-of-range addresses are filtered before any array index is formed.
      if (wr_in_range) begin
         wr_old = mem_q[waddr_i];
      end
      for (int b = 0; b < int'(BeWidth); b++) begin
         wr_merged[8*b +: 8] = rf_merge_byte(wr_old[8*b +: 8], wdata_i[8*b +: 8], wbe_i[b]);
      end

      if (scrub_we) begin
         mem_d[scrub_addr] = '0;
      end else if (wr_en) begin
         mem_d[waddr_i] = wr_merged;
      end

      if (rreq_i) begin
         if (busy || !rd_in_range) begin
            rerr_d  = 1'b1;
            rdata_d = '0;
         end else if (ZeroWord0 && (raddr_i == '0)) begin
            rdata_d = '0;
         end else if (wr_en && (waddr_i == raddr_i)) begin
            rdata_d = wr_merged;
         end else begin
            rdata_d = mem_q[raddr_i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         werr_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         werr_q   <= werr_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
      end
   end

   assign busy_o   = busy;
   assign werr_o   = werr_q;
   assign rvalid_o = rvalid_q;
   assign rerr_o   = rerr_q;
   assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ibex_l2_rf_bank.sv
// Directed and randomized checks of ibex_l2_rf_bank against an array-based reference model.
module tb_ibex_l2_rf_bank;

   localparam int DW = 32;
   localparam int NW = 28;
   localparam int AW = 5;
   localparam int BW = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i;
   logic          busy_o;
   logic          we_i;
   logic [AW-1:0] waddr_i;
   logic [DW-1:0] wdata_i;
   logic [BW-1:0] wbe_i;
   logic          werr_o;
   logic          rreq_i;
   logic [AW-1:0] raddr_i;
   logic          rvalid_o;
   logic [DW-1:0] rdata_o;
   logic          rerr_o;

   always #5 clk_i = ~clk_i;

   ibex_l2_rf_bank dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .busy_o  (busy_o),
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .wbe_i   (wbe_i),
      .werr_o  (werr_o),
      .rreq_i  (rreq_i),
      .raddr_i (raddr_i),
      .rvalid_o(rvalid_o),
      .rdata_o (rdata_o),
      .rerr_o  (rerr_o)
   );

   logic [DW-1:0] model [NW];
   int            scrub_left;
   logic          exp_werr, exp_valid, exp_rerr;
   logic [DW-1:0] exp_rdata;
   int            n_assert = 0;
   int            n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NW; i++) model[i] = '0;
      scrub_left = 0;
      exp_werr   = 1'b0;
      exp_valid  = 1'b0;
      exp_rerr   = 1'b0;
      exp_rdata  = '0;
   endtask

   task automatic idle();
      clear_i = 1'b0;
      we_i    = 1'b0;
      waddr_i = '0;
      wdata_i = '0;
      wbe_i   = '0;
      rreq_i  = 1'b0;
      raddr_i = '0;
   endtask

   // Advance one clock, update the reference model with the applied inputs, check outputs.
   task automatic step();
      @(posedge clk_i);
      exp_werr  = 1'b0;
      exp_valid = rreq_i;
      if (scrub_left > 0) begin
         if (we_i) exp_werr = 1'b1;
         if (rreq_i) begin
            exp_rerr  = 1'b1;
            exp_rdata = '0;
         end
         model[NW - scrub_left] = '0;
         scrub_left--;
      end else begin
         if (we_i) begin
            if (int'(waddr_i) >= NW) exp_werr = 1'b1;
            else if (waddr_i != 0)
               for (int b = 0; b < BW; b++)
                  if (wbe_i[b]) model[waddr_i][8*b +: 8] = wdata_i[8*b +: 8];
         end
         if (rreq_i) begin
            if (int'(raddr_i) >= NW) begin
               exp_rerr  = 1'b1;
               exp_rdata = '0;
            end else begin
               exp_rerr  = 1'b0;
               exp_rdata = (raddr_i == 0) ? '0 : model[raddr_i];
            end
         end
         if (clear_i) scrub_left = NW;
      end
      #1;
      chk("busy", 64'(busy_o), 64'(scrub_left > 0));
      chk("werr", 64'(werr_o), 64'(exp_werr));
      chk("rvalid", 64'(rvalid_o), 64'(exp_valid));
      chk("rdata", 64'(rdata_o), 64'(exp_rdata));
      if (exp_valid) chk("rerr", 64'(rerr_o), 64'(exp_rerr));
   endtask

   initial begin
      int cnt;
      int guard;
      rst_ni = 1'b0;
      idle();
      model_reset();
      #3;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_rvalid", 64'(rvalid_o), 64'd0);
      chk("rst_werr", 64'(werr_o), 64'd0);
      chk("rst_rerr", 64'(rerr_o), 64'd0);
      chk("rst_rdata", 64'(rdata_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Full write then read.
      we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; wbe_i = 4'hF;
      step();
      idle(); rreq_i = 1'b1; raddr_i = 5'd5;
      step();
      chk("rd5", 64'(rdata_o), 64'hDEADBEEF);

      // Partial write colliding with a read of the same word.
      idle(); we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'h11223344; wbe_i = 4'b0101;
      rreq_i = 1'b1; raddr_i = 5'd5;
      step();
      chk("fwd5", 64'(rdata_o), 64'hDE22BE44);

      // Word 0 is hardwired to zero.
      idle(); we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF; wbe_i = 4'hF;
      step();
      idle(); rreq_i = 1'b1; raddr_i = 5'd0;
      step();
      chk("rd0", 64'(rdata_o), 64'd0);

      // Out-of-range write and read.
      idle(); we_i = 1'b1; waddr_i = 5'd30; wdata_i = 32'hCAFEF00D; wbe_i = 4'hF;
      step();
      chk("werr30", 64'(werr_o), 64'd1);
      idle();
      step();
      idle(); rreq_i = 1'b1; raddr_i = 5'd30;
      step();
      chk("rerr30", 64'(rerr_o), 64'd1);

      // Fill, scrub, verify zero.
      for (int i = 1; i < NW; i++) begin
         idle(); we_i = 1'b1; waddr_i = AW'(i); wdata_i = DW'(i); wbe_i = 4'hF;
         step();
      end
      idle(); clear_i = 1'b1;
      step();
      idle();
      cnt   = busy_o ? 1 : 0;
      guard = 0;
      while (busy_o && guard < 60) begin
         idle();
         if (cnt == 3) begin rreq_i = 1'b1; raddr_i = 5'd3; end
         if (cnt == 5) clear_i = 1'b1;
         step();
         if (busy_o) cnt++;
         guard++;
      end
      chk("busy_len", 64'(cnt), 64'(NW));
      for (int i = 1; i < NW; i++) begin
         idle(); rreq_i = 1'b1; raddr_i = AW'(i);
         step();
         chk("scrubbed", 64'(rdata_o), 64'd0);
      end

      // Reset mid-scrub.
      idle(); we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h12345678; wbe_i = 4'hF;
      step();
      idle(); clear_i = 1'b1;
      step();
      idle();
      for (int i = 0; i < 9; i++) step();
      rst_ni = 1'b0;
      #1;
      model_reset();
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_rvalid", 64'(rvalid_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'hA5A5A5A5; wbe_i = 4'hF;
      step();
      idle(); rreq_i = 1'b1; raddr_i = 5'd7;
      step();
      chk("post_rst_rd", 64'(rdata_o), 64'hA5A5A5A5);

      // Randomized traffic, reads biased toward the write address for collisions.
      for (int i = 0; i < 800; i++) begin
         idle();
         clear_i = ($urandom_range(0, 59) == 0);
         we_i    = $urandom_range(0, 1);
         waddr_i = AW'($urandom_range(0, 31));
         wdata_i = $urandom;
         wbe_i   = BW'($urandom_range(0, 15));
         rreq_i  = $urandom_range(0, 1);
         raddr_i = ($urandom_range(0, 2) == 0) ? waddr_i : AW'($urandom_range(0, 31));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
